// File: rtl/swt_led_pkg.sv
// swt_led_pkg: mode encodings and debounce counter sizing shared by swt_led_ctrl
package swt_led_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_INVERT = 2'b11
  } mode_t;
  function automatic int db_cnt_w(input int db_cycles);
    return $clog2(db_cycles + 1);
  endfunction
endpackage

// File: rtl/swt_debounce.sv
// swt_debounce: two-flop synchronizer plus per-bit debouncer; busy while a change is pending
module swt_debounce
  import swt_led_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic busy
);
  localparam int CW = db_cnt_w(DB_CYCLES);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
      db   <= 1'b0;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == db) cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        db  <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
  assign busy = (cnt != '0) || (sync[1] != db);
endmodule

// File: rtl/swt_led_ctrl.sv
// swt_led_ctrl: debounced switches drive LEDs in PASS/COUNT/SHIFT/INVERT modes
// Optional parity output when SWT_LED_PARITY_EN is defined.
module swt_led_ctrl
  import swt_led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] swt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             stable
`ifdef SWT_LED_PARITY_EN
  ,
  output logic             parity
`endif
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [WIDTH-1:0] db, busy, cnt, pat, led_d;
  logic [1:0]       msync1;
  mode_t            msync, cur_mode;
  logic [PW-1:0]    pre;
  logic             entry, tick, rise, db0_q;
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_db
      swt_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk  (clk),
        .reset(reset),
        .raw  (swt[i]),
        .db   (db[i]),
        .busy (busy[i])
      );
    end
  endgenerate
  always_comb begin
    entry = msync != cur_mode;
    tick  = pre == PW'(TICK_DIV - 1);
    rise  = db[0] & ~db0_q;
    led_d = msync == MODE_PASS  ? db  :
            msync == MODE_COUNT ? cnt :
            msync == MODE_SHIFT ? pat : ~db;
  end
  // mode entry clears the count / reloads the pattern ahead of any other update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msync1   <= '0;
      msync    <= MODE_PASS;
      cur_mode <= MODE_PASS;
      pre      <= '0;
      cnt      <= '0;
      pat      <= WIDTH'(1);
      db0_q    <= 1'b0;
      led      <= '0;
      stable   <= 1'b1;
    end else begin
      msync1   <= mode;
      msync    <= mode_t'(msync1);
      cur_mode <= msync;
      db0_q    <= db[0];
      pre      <= (entry || tick) ? '0 : pre + 1'b1;
      if (msync == MODE_COUNT) cnt <= entry ? '0 : cnt + WIDTH'(rise);
      if (msync == MODE_SHIFT)
        pat <= entry ? WIDTH'(1) : (tick && db[0]) ? {pat[WIDTH-2:0], pat[WIDTH-1]} : pat;
      led      <= led_d;
      stable   <= ~|busy;
    end
  end
`ifdef SWT_LED_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity <= 1'b0;
    else parity <= ^db;
  end
`endif
endmodule

// File: tb/tb_swt_led_ctrl.sv
// tb_swt_led_ctrl: directed self-checking bench for swt_led_ctrl (WIDTH=8, DB_CYCLES=4, TICK_DIV=4)
module tb_swt_led_ctrl;
  import swt_led_pkg::*;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] swt = 8'h00;
  logic [1:0] mode = MODE_PASS;
  logic [7:0] led;
  logic       stable;
`ifdef SWT_LED_PARITY_EN
  logic       parity;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] prev, nxt;

  swt_led_ctrl #(.WIDTH(8), .DB_CYCLES(4), .TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .swt   (swt),
    .mode  (mode),
    .led   (led),
    .stable(stable)
`ifdef SWT_LED_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    tick(2);
    chk("rst_led", led, 8'h00);
    chk("rst_stable", stable, 1'b1);
`ifdef SWT_LED_PARITY_EN
    chk("rst_parity", parity, 1'b0);
`endif
    reset = 1'b0;
    tick(3);
    // PASS: clean edge reaches led on the 7th clock
    swt = 8'hA5;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 7) chk("pass_hold", led, 8'h00);
      if (k >= 3 && k <= 6) chk("pass_busy", stable, 1'b0);
    end
    chk("pass_led", led, 8'hA5);
    chk("pass_stable", stable, 1'b1);
    swt = 8'h00;
    tick(10);
    chk("pass_zero", led, 8'h00);
    // 3-clock glitch must be rejected
    swt = 8'h08;
    tick(3);
    swt = 8'h00;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("glitch_led", led, 8'h00);
    end
    chk("glitch_stable", stable, 1'b1);
    // COUNT with wrap
    mode = MODE_COUNT;
    tick(6);
    chk("count_entry", led, 8'h00);
    for (int p = 1; p <= 257; p++) begin
      swt[0] = 1'b1;
      tick(6);
      swt[0] = 1'b0;
      tick(6);
      if (p == 255) chk("count_ff", led, 8'hFF);
      if (p == 256) chk("count_wrap", led, 8'h00);
    end
    tick(4);
    chk("count_257", led, 8'h01);
    mode = MODE_PASS;
    tick(4);
    mode = MODE_COUNT;
    tick(5);
    chk("count_reentry", led, 8'h00);
    // SHIFT rotation, one step every 4 clocks
    mode = MODE_PASS;
    swt  = 8'h01;
    tick(10);
    chk("shift_pre", led, 8'h01);
    mode = MODE_SHIFT;
    for (int k = 0; k < 40 && led !== 8'h02; k++) tick();
    chk("shift_first", led, 8'h02);
    prev = 8'h02;
    for (int k = 0; k < 7; k++) begin
      nxt = {prev[6:0], prev[7]};
      tick(3);
      chk("shift_wait", led, prev);
      tick();
      chk("shift_step", led, nxt);
      prev = nxt;
    end
    // one tick still sees db[0]=1 while the drop is being debounced
    swt = 8'h00;
    tick(20);
    chk("shift_hold", led, 8'h02);
    // INVERT, then reset mid-debounce
    mode = MODE_INVERT;
    swt  = 8'h0F;
    tick(12);
    chk("inv_led", led, 8'hF0);
    swt = 8'hFF;
    tick(3);
    reset = 1'b1;
    #1;
    chk("rst_mid_led", led, 8'h00);
    chk("rst_mid_stable", stable, 1'b1);
    tick(2);
    chk("rst_hold_led", led, 8'h00);
    chk("rst_hold_stable", stable, 1'b1);
    reset = 1'b0;
    tick(4);
    chk("post_rst_pending", led, 8'hFF);
    tick(4);
    chk("post_rst_settled", led, 8'h00);
`ifdef SWT_LED_PARITY_EN
    mode = MODE_PASS;
    swt  = 8'h07;
    tick(10);
    chk("parity_odd", parity, 1'b1);
    swt = 8'h03;
    tick(10);
    chk("parity_even", parity, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/swt_led_ctrl.md
SWT_LED_CTRL -- requirements
Module: swt_led_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the number of switch inputs and LED outputs (range 2..32).
REQ-002 Parameter DB_CYCLES, default 4, is the number of consecutive stable clocks required to accept a switch change (range 1..65535).
REQ-003 Parameter TICK_DIV, default 4, is the clock divider for the SHIFT-mode rotation tick (range 1..2^24).
REQ-004 clk  input  1  single system clock; all state is updated on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 swt  input  WIDTH  raw, asynchronous switch levels.
REQ-007 mode  input  2  raw, asynchronous mode select: 00 PASS, 01 COUNT, 10 SHIFT, 11 INVERT.
REQ-008 led  output  WIDTH  registered LED drive.
REQ-009 stable  output  1  registered flag, high when no bit has a pending (unaccepted) change.
REQ-010 parity  output  1  registered XOR of all debounced bits; this port exists only when SWT_LED_PARITY_EN is defined.

Function
REQ-011 Each swt bit and each mode bit shall pass through a two-flop synchronizer.
REQ-012 Each bit shall have its own debouncer: if sync != db, the counter increments; when the counter reaches DB_CYCLES-1, db takes the sync value and the counter clears. If sync == db, the counter clears.
REQ-013 A glitch shorter than DB_CYCLES clocks shall never change db.
REQ-014 The mode shall be taken from the synchronized mode bits without debouncing. A change in the synchronized mode value shall be detected as mode entry.
REQ-015 PASS: led = db, registered.
REQ-016 COUNT: led = count of db[0] rising edges, WIDTH bits wide, wrapping from 2^WIDTH-1 to 0. The count shall clear to 0 on the first clock of mode entry.
REQ-017 SHIFT: on mode entry the pattern shall load 1. On each tick, while db[0]=1, the pattern shall rotate left by one (MSB to LSB). While db[0]=0, the pattern shall hold. led = pattern.
REQ-018 The tick shall be a one-clock pulse every TICK_DIV clocks, from a free-running prescaler. The prescaler shall restart at 0 on mode entry.
REQ-019 INVERT: led = ~db.
REQ-020 End-to-end latency in PASS mode, from a clean swt edge to led, shall be exactly DB_CYCLES+3 clocks (2 synchronizer, DB_CYCLES debouncer, 1 output).
REQ-021 stable = 1 only when every debouncer counter is 0 and sync == db for every bit.
REQ-022 If a db[0] rise coincides with mode entry into COUNT, the clear shall take priority and the count shall be 0.

Reset
REQ-023 While reset is high, all synchronizers, db and counters shall be 0, led = 0, stable = 1, parity = 0, the prescaler = 0, the pattern = 1, and the current mode = PASS.
REQ-024 Reset asserted mid-operation shall abort any pending debounce immediately. After release, the block shall treat current switch levels as new changes subject to REQ-012.

Configuration
REQ-025 When macro SWT_LED_PARITY_EN is defined, the parity port and its register shall exist and update every clock from db.
REQ-026 When SWT_LED_PARITY_EN is undefined, no parity port or logic shall exist, and all other behaviour shall be identical.

Structure
REQ-027 Package swt_led_pkg shall hold the mode encodings (MODE_PASS, MODE_COUNT, MODE_SHIFT, MODE_INVERT) and a localparam function for the debounce counter width, $clog2(DB_CYCLES+1).
REQ-028 Sub-module swt_debounce shall implement one synchronizer plus debouncer bit, with parameter DB_CYCLES and outputs db and busy. swt_led_ctrl shall instantiate it WIDTH times in a generate loop.

Verification (WIDTH=8, DB_CYCLES=4, TICK_DIV=4)
REQ-029 The bench shall cover these directed scenarios:
- Reset, then PASS with swt=8'h00 to 8'hA5 held -> led=8'hA5 exactly 7 clocks after the sampling edge; stable low during the interval.
- PASS, swt[3] glitch high for 3 clocks -> led unchanged at 8'h00 throughout; stable returns to 1.
- COUNT, 257 clean db[0] pulses (each level held 6 clocks) -> led=8'h01 after wrap; re-entry into COUNT -> led=8'h00.
- SHIFT, swt[0]=1 held -> led sequence 01,02,04,...,80,01, one step every 4 clocks; drop swt[0] -> led holds value.
- INVERT with swt=8'h0F -> led=8'hF0; assert reset mid-debounce of a change to 8'hFF -> led=8'h00, stable=1 during reset.
- With SWT_LED_PARITY_EN defined, swt=8'h07 -> parity=1; swt=8'h03 -> parity=0; without the macro, the build has no parity port.
